// File: rtl/bitmap_release.sv
// bitmap_release: queues 1-based slot-release requests, decodes them to
// one-hot masks and applies them, together with same-cycle allocation
// commits, to a 64-slot occupancy bitmap with registered error pulses.
module bitmap_release #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        free_valid,
   output logic        free_ready,
   input  logic [6:0]  free_pos,
   input  logic        alloc_valid,
   input  logic [63:0] alloc_mask,
   output logic [63:0] bitmap_out,
   output logic [6:0]  free_count,
   output logic        err_invalid,
   output logic        err_double_free,
   output logic        err_double_alloc,
   output logic        busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [6:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic             push;
   logic             pop;

   logic [6:0]       head_pos;
   logic             head_legal;
   logic [63:0]      head_mask;

   logic             dec_valid;
   logic             dec_invalid;
   logic [63:0]      dec_mask;

   logic             alloc_onehot;
   logic [63:0]      alloc_eff;
   logic             dec_hit;
   logic [63:0]      free_eff;
   logic [63:0]      bitmap_next;
   logic [6:0]       ones_next;

   // Ready depends only on the registered occupancy, never on free_valid.
   assign free_ready = fifo_count < CNT_W'(FIFO_DEPTH);
   assign push       = free_valid & free_ready;
   // The decode stage never stalls, so the head pops whenever present.
   assign pop        = (fifo_count != '0);
   assign busy       = pop | dec_valid;

   // Request storage; only the pointers and count carry reset state.
   // NOTE: the data array is left unreset on purpose -- an entry is only read
   // after it was written, so resetting it would just cost flops and routing.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= free_pos;
   end

   // FIFO pointers wrap naturally because the depth is a power of two.
   // NOTE: all sequential state uses non-blocking assignment so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (!push && pop) fifo_count <= fifo_count - 1'b1;
      end
   end

   // Head decode: legal positions are 1..64, anything else is flagged.
   assign head_pos   = fifo_mem[rd_ptr];
   assign head_legal = (head_pos != 7'd0) && (head_pos <= 7'd64);
   assign head_mask  = head_legal ? (64'd1 << (head_pos - 7'd1)) : '0;

   // Decode register: loads the popped head, otherwise drops its valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_valid   <= 1'b0;
         dec_invalid <= 1'b0;
         dec_mask    <= '0;
      end else begin
         dec_valid <= pop;
         if (pop) begin
            dec_mask    <= head_mask;
            dec_invalid <= !head_legal;
         end
      end
   end

   // Effective masks: a clear happens first, then the alloc is OR-ed back in,
   // so a same-cycle alloc and free of one slot leaves it occupied.
   assign alloc_onehot = (alloc_mask != '0) && ((alloc_mask & (alloc_mask - 64'd1)) == '0);
   assign alloc_eff    = (alloc_valid && alloc_onehot) ? alloc_mask : '0;
   assign dec_hit      = dec_valid && !dec_invalid;
   assign free_eff     = (dec_hit && ((dec_mask & bitmap_out) != '0)) ? dec_mask : '0;
   assign bitmap_next  = (bitmap_out & ~free_eff) | alloc_eff;

   // Population count of the next bitmap so free_count tracks it exactly.
   // NOTE: the accumulator gets a default before the loop so no latch is inferred.
   always_comb begin
      ones_next = '0;
      for (int i = 0; i < 64; i++) ones_next = ones_next + 7'(bitmap_next[i]);
   end

   // Apply stage: bitmap, its free count and the one-cycle error pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitmap_out       <= '0;
         free_count       <= 7'd64;
         err_invalid      <= 1'b0;
         err_double_free  <= 1'b0;
         err_double_alloc <= 1'b0;
      end else begin
         bitmap_out       <= bitmap_next;
         free_count       <= 7'd64 - ones_next;
         err_invalid      <= (alloc_valid && !alloc_onehot) || (dec_valid && dec_invalid);
         err_double_free  <= dec_hit && ((dec_mask & bitmap_out) == '0);
         err_double_alloc <= (alloc_eff & bitmap_out) != '0;
      end
   end

endmodule
